// File: rtl/flag_tick_bcd_counter_pkg.sv
// flag_tick_pkg: shared state encoding, digit width and default terminal values
package flag_tick_pkg;
  localparam int DIGIT_W = 4;
  localparam int TENS_MAX_DEF = 5;
  localparam int ONES_MAX_DEF = 9;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
endpackage

// File: rtl/flag_tick_bcd_counter_if.sv
// flag_tick_bcd_counter_if: flag/control inputs and BCD/strobe outputs of the counter
interface flag_tick_bcd_counter_if;
  import flag_tick_pkg::*;
  logic flag_in;
  logic start;
  logic stop;
  logic clear;
  logic tick;
  logic wrap;
  logic running;
  logic [DIGIT_W-1:0] ones;
  logic [DIGIT_W-1:0] tens;
  modport master(output flag_in, start, stop, clear, input tick, ones, tens, wrap, running);
  modport slave(input flag_in, start, stop, clear, output tick, ones, tens, wrap, running);
endinterface

// File: rtl/flag_tick_bcd_counter_digit.sv
// bcd_digit: modulo-(MAX+1) digit with carry out on increment at MAX
module bcd_digit
  import flag_tick_pkg::*;
#(
  parameter int MAX = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic               clr,
  output logic [DIGIT_W-1:0] q,
  output logic               carry
);
  logic at_max;
  assign at_max = q == DIGIT_W'(MAX);
  assign carry = inc && at_max;
  // clear beats increment; increment at MAX rolls back to zero
  always_ff @(posedge clk)
    q <= (reset || clr) ? '0 : inc ? (at_max ? '0 : q + 1'b1) : q;
endmodule

// File: rtl/flag_tick_bcd_counter.sv
// flag_tick_bcd_counter: counts flag level changes into a 2-digit BCD count under start/stop/clear control
module flag_tick_bcd_counter
  import flag_tick_pkg::*;
#(
  parameter int   TENS_MAX  = TENS_MAX_DEF,
  parameter int   ONES_MAX  = ONES_MAX_DEF,
  parameter logic FLAG_INIT = 1'b1
) (
  input logic clk,
  input logic reset,
  flag_tick_bcd_counter_if.slave bus
);
  if (TENS_MAX > 9 || ONES_MAX > 9) begin : g_bad_max
    $error("flag_tick_bcd_counter: TENS_MAX and ONES_MAX must be <= 9");
  end
  state_t state_q, state_d;
  logic flag_d, toggle, cnt_en, ones_carry, tens_carry;
  logic [DIGIT_W-1:0] ones, tens;
  assign toggle = bus.flag_in ^ flag_d;
  assign cnt_en = state_q == RUN && toggle && !bus.clear;
  assign bus.ones = ones;
  assign bus.tens = tens;
  // clear > stop > start; stop never leaves IDLE
  always_comb
    state_d = bus.clear ? IDLE
            : bus.stop  ? (state_q == IDLE ? IDLE : PAUSE)
            : bus.start ? RUN
            : state_q;
  // state, flag history and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      flag_d      <= FLAG_INIT;
      bus.tick    <= 1'b0;
      bus.wrap    <= 1'b0;
      bus.running <= 1'b0;
    end else begin
      state_q     <= state_d;
      flag_d      <= bus.flag_in;
      bus.tick    <= toggle;
      bus.wrap    <= tens_carry;
      bus.running <= state_d == RUN;
    end
  end
  bcd_digit #(.MAX(ONES_MAX)) u_ones (
    .clk(clk), .reset(reset), .inc(cnt_en), .clr(bus.clear), .q(ones), .carry(ones_carry)
  );
  bcd_digit #(.MAX(TENS_MAX)) u_tens (
    .clk(clk), .reset(reset), .inc(ones_carry), .clr(bus.clear), .q(tens), .carry(tens_carry)
  );
endmodule

// File: tb/tb_flag_tick_bcd_counter.sv
// tb_flag_tick_bcd_counter: directed plus random stimulus checked against an integer count model
module tb_flag_tick_bcd_counter;
  localparam int T_MAX = 5;
  localparam int O_MAX = 9;
  localparam int MOD = (T_MAX + 1) * (O_MAX + 1);
  logic clk = 1'b0;
  logic reset;
  logic f;
  int errors = 0, checks = 0, wraps = 0, ticks = 0;
  int m_cnt = 0, m_st = 0;
  bit m_prev = 1'b1, m_tick = 1'b0, m_wrap = 1'b0, m_run = 1'b0;
  flag_tick_bcd_counter_if bus();
  flag_tick_bcd_counter #(.TENS_MAX(T_MAX), .ONES_MAX(O_MAX), .FLAG_INIT(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task model_step();
    bit tog;
    tog = bus.flag_in != m_prev;
    if (reset) begin
      m_cnt = 0; m_st = 0; m_prev = 1'b1; m_tick = 0; m_wrap = 0; m_run = 0;
    end else begin
      m_tick = tog;
      m_wrap = 0;
      if (m_st == 1 && tog && !bus.clear) begin
        if (m_cnt == MOD - 1) begin m_cnt = 0; m_wrap = 1; end
        else m_cnt++;
      end
      if (bus.clear) begin m_cnt = 0; m_st = 0; end
      else if (bus.stop) begin if (m_st != 0) m_st = 2; end
      else if (bus.start) m_st = 1;
      m_run = m_st == 1;
      m_prev = bus.flag_in;
    end
  endtask
  task cyc(input logic rr, input logic ss, input logic pp, input logic cc);
    reset = rr; bus.flag_in = f; bus.start = ss; bus.stop = pp; bus.clear = cc;
    @(posedge clk);
    model_step();
    #1;
    check("tick", int'(bus.tick), int'(m_tick));
    check("wrap", int'(bus.wrap), int'(m_wrap));
    check("running", int'(bus.running), int'(m_run));
    check("ones", int'(bus.ones), m_cnt % (O_MAX + 1));
    check("tens", int'(bus.tens), m_cnt / (O_MAX + 1));
    wraps += int'(bus.wrap);
    ticks += int'(bus.tick);
  endtask
  task tog(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      f = ~f;
      cyc(0, 0, 0, 0);
      repeat (gap - 1) cyc(0, 0, 0, 0);
    end
  endtask
  initial begin
    f = 1'b1;
    repeat (3) cyc(1, 0, 0, 0);
    ticks = 0;
    repeat (10) cyc(0, 0, 0, 0);
    check("reset_no_tick", ticks, 0);
    cyc(0, 1, 0, 0);
    ticks = 0;
    tog(7, 20);
    check("basic_ticks", ticks, 7);
    check("basic_ones", int'(bus.ones), 7);
    check("basic_tens", int'(bus.tens), 0);
    check("basic_running", int'(bus.running), 1);
    wraps = 0;
    tog(60, 3);
    check("wrap_once", wraps, 1);
    tog(16, 3);
    check("at_23", int'(bus.tens) * 10 + int'(bus.ones), 23);
    ticks = 0;
    f = ~f;
    cyc(0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0);
    tog(5, 3);
    check("pause_ticks", ticks, 6);
    check("pause_hold", int'(bus.tens) * 10 + int'(bus.ones), 24);
    check("pause_running", int'(bus.running), 0);
    cyc(0, 1, 0, 0);
    tog(1, 3);
    check("resume", int'(bus.tens) * 10 + int'(bus.ones), 25);
    tog(16, 3);
    check("at_41", int'(bus.tens) * 10 + int'(bus.ones), 41);
    f = ~f;
    cyc(0, 1, 1, 1);
    check("clr_count", int'(bus.tens) * 10 + int'(bus.ones), 0);
    check("clr_tick", int'(bus.tick), 1);
    check("clr_wrap", int'(bus.wrap), 0);
    check("clr_running", int'(bus.running), 0);
    repeat (2) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    tog(59, 3);
    check("at_59", int'(bus.tens) * 10 + int'(bus.ones), 59);
    f = ~f;
    cyc(1, 0, 0, 0);
    check("rst_count", int'(bus.tens) * 10 + int'(bus.ones), 0);
    check("rst_tick", int'(bus.tick), 0);
    check("rst_wrap", int'(bus.wrap), 0);
    repeat (3) cyc(0, 0, 0, 0);
    repeat (4000) begin
      f = f ^ ($urandom_range(0, 2) == 0);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 23) == 0, $urandom_range(0, 63) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/flag_tick_bcd_counter.md
Name: flag_tick_bcd_counter

Overview:
- Downstream consumer of the divided-clock square wave (`flag`) from the free-running binary divider.
- Converts every level change of `flag` into a one-cycle tick strobe.
- Accumulates ticks in a 2-digit BCD counter (default modulo 60) under a start/stop/clear control FSM.
- Exports the BCD digits, a wrap strobe and a running status for display/LED logic.

Parameters:
- `TENS_MAX`, default 5: terminal value of the tens digit (0..9).
- `ONES_MAX`, default 9: terminal value of the ones digit (0..9).
- `FLAG_INIT`, default 1'b1: reset value of the internal flag history register. It matches the upstream flag reset value, so no spurious tick is produced out of reset.

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flag_in` in 1: toggling flag from the upstream divider, same clock domain (no synchroniser).
- `start` in 1: level-sampled; request RUN.
- `stop` in 1: level-sampled; request PAUSE.
- `clear` in 1: level-sampled; zero counts and go to IDLE.
- `tick` out 1: one-cycle pulse per detected `flag_in` change.
- `ones` out 4: BCD ones digit.
- `tens` out 4: BCD tens digit.
- `wrap` out 1: one-cycle pulse when the count rolls `TENS_MAX`/`ONES_MAX` -> 00.
- `running` out 1: high while the FSM is in RUN.

Behaviour:
- **Reset** (`reset`=1 at a rising edge):
  - `flag_d` <= `FLAG_INIT`.
  - `tick`, `wrap`, `running` <= 0.
  - `ones`, `tens` <= 0.
  - state <= IDLE.
  - Reset overrides all other inputs. Asserted mid-count, it zeroes the count on that edge with no wrap pulse.
- **Edge detect:**
  - `flag_d` <= `flag_in` every cycle.
  - toggle = `flag_in` ^ `flag_d` (combinational).
  - `tick` <= toggle (registered). `tick` goes high the cycle after `flag_in` changes and pulses in every state, including IDLE and PAUSE.
  - With the upstream default, ticks are 1001 cycles apart.
- **FSM states:** IDLE, RUN, PAUSE. Control priority is `clear` > `stop` > `start`.
  - `clear` from any state: state <= IDLE; `ones`, `tens` <= 0.
  - IDLE: `start` -> RUN; `stop` is ignored.
  - RUN: `stop` -> PAUSE; `start` has no effect.
  - PAUSE: `start` -> RUN; the count is held.
  - `running` is the registered state==RUN flag (high on the same edge the state enters RUN).
- **Counting:** on an edge where state==RUN (current state) and toggle=1, and `clear`=0:
  - If `ones` != `ONES_MAX`: `ones` + 1.
  - Else `ones` <= 0, and:
    - if `tens` != `TENS_MAX`: `tens` + 1;
    - else `tens` <= 0 and `wrap` <= 1.
  - The count updates on the same edge that `tick` rises, so the new count and `tick` are visible together.
- **Simultaneous events:**
  - toggle + `stop` while in RUN: the tick is counted, then the state goes to PAUSE.
  - toggle + `start` while in IDLE/PAUSE: not counted. Counting begins with the next toggle.
  - toggle + `clear`: `clear` wins; count = 00, no wrap, `tick` still pulses.
  - `start` + `stop` together: `stop` wins (IDLE stays IDLE, RUN -> PAUSE, PAUSE stays PAUSE).
- **Strobe widths:** `wrap` and `tick` are exactly one cycle wide; both are 0 in all other cycles.
- **Digit range:** digits never leave 0..`TENS_MAX` / 0..`ONES_MAX`. There is no illegal BCD state reachable.
- **Parameter check:** `ONES_MAX` = 0 or `TENS_MAX` = 0 is legal. Elaboration checks that both are <= 9.

Decomposition:
- Shared package `flag_tick_pkg` holds:
  - state typedef/encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2);
  - BCD digit width constant (4);
  - default `TENS_MAX`/`ONES_MAX` constants.
- One natural sub-module, `bcd_digit`, instantiated twice:
  - function: modulo-(MAX+1) 4-bit digit;
  - inputs: `inc`, `clr`; output: `carry` (= `inc` && digit==MAX);
  - synchronous `reset`.
- The FSM and edge detector live in the top module.

Test Plan:
- **Reset:** hold `reset` 3 cycles with `flag_in`=1, then release -> `tick`=0, `ones`=`tens`=0, `running`=0; no tick for 10 cycles.
- **Basic run:** pulse `start`, then toggle `flag_in` 7 times, 20 cycles apart -> 7 single-cycle ticks, each 1 cycle after its toggle; final `tens`=0, `ones`=7; `running`=1.
- **Wrap:** in RUN, apply 60 toggles -> the count passes 09->10 and 59->00. `wrap` is high exactly once, in the cycle `ones`/`tens` become 0/0.
- **Pause/hold:** at count 23, assert `stop` on the same cycle as a toggle, then apply 5 more toggles -> count 24 held; 6 ticks total; `running`=0. Then `start` plus one toggle -> 25.
- **Clear priority:** at count 41, assert `clear`, `stop` and `start` together with a toggle -> count 00, state IDLE, `running`=0, `tick`=1, `wrap`=0.
- **Reset mid-operation:** at count 59, assert `reset` on the same cycle as a toggle -> 00, `wrap`=0, `tick`=0, `flag_d`=`FLAG_INIT`.
